// File: rtl/signmag_accum25.sv
// Sign-magnitude product accumulator: sums N_TERMS terms per window with
// 25-bit saturation and presents each window result through a valid/ready register.
module signmag_accum25 #(
    parameter int N_TERMS = 9,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [23:0] in_mag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] out_data,
    output logic        out_sat,
    output logic        busy
);

    typedef enum logic {IDLE, ACC} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    state_t           state, state_nx;
    logic [24:0]      acc, acc_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic             sat_acc, sat_acc_nx;
    logic             out_valid_nx, out_sat_nx;
    logic [24:0]      out_data_nx;

    logic        accept, closing;
    logic [24:0] term, s_sat;
    logic [25:0] s;
    logic        sat_hi, sat_lo, sat_now;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign busy     = (count != '0);

    // Negating a zero magnitude wraps back to zero, so no negative zero survives.
    assign term    = in_sign ? (~{1'b0, in_mag} + 25'd1) : {1'b0, in_mag};
    assign s       = {acc[24], acc} + {term[24], term};
    // The 26-bit sum fits in 25 bits exactly when its top two bits agree.
    assign sat_hi  = !s[25] && s[24];
    assign sat_lo  = s[25] && !s[24];
    assign sat_now = sat_hi || sat_lo;
    assign s_sat   = sat_hi ? 25'h0FFFFFF : (sat_lo ? 25'h1000000 : s[24:0]);

    assign closing = accept && ((N_TERMS == 1) || (state == ACC && count == LAST));

    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        count_nx     = count;
        sat_acc_nx   = sat_acc;
        out_valid_nx = out_valid;
        out_data_nx  = out_data;
        out_sat_nx   = out_sat;

        if (out_valid && out_ready)
            out_valid_nx = 1'b0;

        if (closing) begin
            out_valid_nx = 1'b1;
            out_data_nx  = s_sat;
            out_sat_nx   = sat_acc || sat_now;
            acc_nx       = '0;
            count_nx     = '0;
            sat_acc_nx   = 1'b0;
            state_nx     = IDLE;
        end else if (accept) begin
            acc_nx     = s_sat;
            count_nx   = count + 1'b1;
            sat_acc_nx = sat_acc || sat_now;
            state_nx   = ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            sat_acc   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            count     <= count_nx;
            sat_acc   <= sat_acc_nx;
            out_valid <= out_valid_nx;
            out_data  <= out_data_nx;
            out_sat   <= out_sat_nx;
        end
    end

endmodule

// File: tb/tb_signmag_accum25.sv
// Directed bench for signmag_accum25: table of 9-term windows plus
// hand-written backpressure, async reset and gapped-input sequences.
module tb_signmag_accum25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [23:0] in_mag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [24:0] out_data;
    logic        out_sat;
    logic        busy;

    int checks = 0;
    int errors = 0;

    signmag_accum25 #(.N_TERMS(9), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_mag(in_mag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    // Window: odd-indexed terms use (sign1, mag1) when alt is set.
    typedef struct {
        logic        alt;
        logic        sign0;
        logic [23:0] mag0;
        logic        sign1;
        logic [23:0] mag1;
        logic [24:0] exp_data;
        logic        exp_sat;
    } win_t;

    win_t wins[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at posedge+1; leaves at the next posedge+1 with in_valid low.
    task automatic term(input logic s, input logic [23:0] m);
        in_valid = 1'b1;
        in_sign  = s;
        in_mag   = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        wins[0] = '{1'b0, 1'b0, 24'd10,      1'b0, 24'd0, 25'd90,        1'b0};
        wins[1] = '{1'b1, 1'b0, 24'd5,       1'b1, 24'd3, 25'd13,        1'b0};
        wins[2] = '{1'b0, 1'b1, 24'd7,       1'b0, 24'd0, 25'h1FFFFC1,   1'b0};
        wins[3] = '{1'b0, 1'b0, 24'hFFFFFF,  1'b0, 24'd0, 25'h0FFFFFF,   1'b1};
        wins[4] = '{1'b0, 1'b0, 24'd1,       1'b0, 24'd0, 25'd9,         1'b0};
        wins[5] = '{1'b0, 1'b1, 24'hFFFFFF,  1'b0, 24'd0, 25'h1000000,   1'b1};
        wins[6] = '{1'b0, 1'b1, 24'd0,       1'b0, 24'd0, 25'd0,         1'b0};
        // Clamps at term 5 then keeps accumulating from the clamped value.
        wins[7] = '{1'b1, 1'b0, 24'h800000,  1'b1, 24'd1, 25'h0FFFFFF,   1'b1};

        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data",  32'(out_data),  32'd0);
        chk("reset_out_sat",   32'(out_sat),   32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < 9; i++) begin
                logic        s;
                logic [23:0] m;
                s = (wins[w].alt && i[0]) ? wins[w].sign1 : wins[w].sign0;
                m = (wins[w].alt && i[0]) ? wins[w].mag1  : wins[w].mag0;
                chk($sformatf("w%0d_in_ready_%0d", w, i), 32'(in_ready), 32'd1);
                term(s, m);
                if (i < 8) begin
                    chk($sformatf("w%0d_busy_%0d", w, i), 32'(busy), 32'd1);
                    chk($sformatf("w%0d_early_valid_%0d", w, i), 32'(out_valid), 32'd0);
                end
            end
            chk($sformatf("w%0d_out_valid", w), 32'(out_valid), 32'd1);
            chk($sformatf("w%0d_out_data", w),  32'(out_data),  32'(wins[w].exp_data));
            chk($sformatf("w%0d_out_sat", w),   32'(out_sat),   32'(wins[w].exp_sat));
            chk($sformatf("w%0d_busy_done", w), 32'(busy),      32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("w%0d_drained", w), 32'(out_valid), 32'd0);
        end

        // Backpressure: first result held while 20 terms are offered.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) term(1'b0, 24'd1);
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        chk("bp_first_data",  32'(out_data),  32'd9);
        in_valid = 1'b1;
        in_sign  = 1'b0;
        in_mag   = 24'd3;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold_valid_%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold_data_%0d", i),  32'(out_data),  32'd9);
            chk($sformatf("bp_hold_busy_%0d", i),  32'(busy),      32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 9; i++) begin
            term(1'b0, 24'd3);
            if (i == 0) chk("bp_handshake_drop", 32'(out_valid), 32'd0);
        end
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        chk("bp_second_data",  32'(out_data),  32'd27);
        chk("bp_second_sat",   32'(out_sat),   32'd0);
        @(posedge clk);
        #1;

        // Async reset with a pending output.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) term(1'b0, 24'd4);
        chk("rst_pend_valid_before", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_pend_valid", 32'(out_valid), 32'd0);
        chk("rst_pend_data",  32'(out_data),  32'd0);
        chk("rst_pend_ready", 32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Async reset after 4 terms of a window.
        for (int i = 0; i < 4; i++) term(1'b0, 24'd5);
        chk("rst_mid_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy",  32'(busy),      32'd0);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fresh window with idle gaps between terms.
        for (int i = 0; i < 9; i++) begin
            term(1'b0, 24'd2);
            if (i[0] && i < 8) begin
                @(posedge clk);
                #1;
                chk($sformatf("gap_busy_%0d", i), 32'(busy), 32'd1);
            end
        end
        chk("after_rst_valid", 32'(out_valid), 32'd1);
        chk("after_rst_data",  32'(out_data),  32'd18);
        chk("after_rst_sat",   32'(out_sat),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/signmag_accum25.md
Name: signmag_accum25

Overview:
- Sequential accumulation stage that sits directly upstream of the 25-bit two's-complement path in the convolution datapath.
- Consumes a stream of sign-magnitude partial products from the multiplier array.
- Negates negative terms to 25-bit two's complement by inverting and adding 1.
- Sums N_TERMS terms per kernel window with saturation, then presents one signed 25-bit window result through a valid/ready output register.

Parameters:
- N_TERMS, 9, number of products per window (3x3 kernel); legal range 1..255.
- CNT_W, 8, width of the term counter; must satisfy 2^CNT_W > N_TERMS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input term present.
- in_ready  output  1  stage accepts a term this cycle.
- in_sign  input  1  1 = negative term.
- in_mag  input  24  unsigned magnitude of the term.
- out_valid  output  1  window result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  25  signed two's-complement window sum.
- out_sat  output  1  saturation occurred in this window (qualified by out_valid).
- busy  output  1  a window is partially accumulated (count != 0).

Behaviour:
- Reset (async, rst_n=0): acc=0, count=0, sat_acc=0, out_valid=0, out_data=0, out_sat=0, busy=0.
- Reset mid-window discards the partial sum and any pending output.
- Accept condition: accept = in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational. No bubble when downstream drains every cycle.
- Term conversion: term = in_sign ? (~{1'b0,in_mag} + 1) : {1'b0,in_mag}, 25 bits.
- in_sign=1 with in_mag=0 yields 0; it is not negative zero.
- Accumulation uses a 26-bit internal sum, s = acc + term, sign-extended.
  - If s > 2^24-1: clamp to 25'h0FFFFFF and set sat_acc.
  - If s < -2^24: clamp to 25'h1000000 and set sat_acc.
- Saturation is sticky until the window closes. Clamped values keep accumulating; they do not wrap.
- States:
  - IDLE: count=0.
  - ACC: 0 < count < N_TERMS.
  - IDLE->ACC on accept when N_TERMS > 1.
  - ACC->ACC on accept while count+1 < N_TERMS.
  - On the accept that completes the window (count == N_TERMS-1, including N_TERMS=1 from IDLE):
    - out_data <= saturated s, out_sat <= sat_acc | (saturation on this term), out_valid <= 1.
    - acc <= 0, count <= 0, sat_acc <= 0, return to IDLE.
- Latency: the result is visible the cycle after the last term is accepted.
- Throughput: 1 term/cycle.
- Output handshake: out_valid stays high, and out_data/out_sat stay stable, until out_valid && out_ready.
- On the handshake cycle, out_valid drops unless a new window completes in the same cycle. In that case out_valid stays 1 and out_data is replaced (back-to-back).
- When out_valid=1 and out_ready=0, in_ready=0 and acc/count hold. A partially accumulated window is frozen, not lost.
- in_valid=0 cycles: no state change; gaps inside a window are allowed.
- busy = (count != 0).
- No combinational path from in_* to out_*. The only combinational path is out_ready -> in_ready.

Test Plan:
- Reset, then 9 terms, all sign=0, mag=24'd10, out_ready=1 -> one cycle after the 9th accept: out_valid=1, out_data=25'd90, out_sat=0; busy=1 during terms 1..8.
- Alternating signs, mags 5,3,5,3,... over 9 terms (+5,-3,+5,-3,+5,-3,+5,-3,+5) -> out_data=25'd13. Then 9 terms of sign=1, mag=7 -> out_data=-63 (25'h1FFFFC1).
- Saturation: 9 terms of sign=0, mag=24'hFFFFFF -> out_data=25'h0FFFFFF, out_sat=1. The following window of 9×(+1) -> out_data=9, out_sat=0 (flag cleared).
- Negative saturation: 9 terms of sign=1, mag=24'hFFFFFF -> out_data=25'h1000000, out_sat=1. Also sign=1, mag=0 contributes 0.
- Backpressure: hold out_ready=0 after the first result, present 20 terms -> in_ready=0 and the first result holds stable. Raise out_ready -> handshake, in_ready=1 the same cycle, the second window completes with the correct sum.
- Async reset asserted mid-window (after 4 terms) and with a pending output -> out_valid=0, busy=0 immediately. The next 9 terms of +2 give out_data=18.
